// File: rtl/sequential_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : sequential_shift_add_multiplier
// Description : Multi-cycle radix-2 shift-add multiplier with an optional
//               two's-complement mode and valid/ready handshakes on both the
//               operand and result sides. Latency is always DATA_WIDTH clocks
//               from the accept edge to Valid_Out.
// Ports       : Clk, Reset (sync, active-high)
//               Valid_In / Ready_Out        operand handshake
//               Signed_Mode_In, Data_A_In, Data_B_In   operands
//               Valid_Out / Ready_In        result handshake
//               Busy_Out                    high while iterating
//               Multiplied_Result_Out       2*DATA_WIDTH-bit product
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_shift_add_multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter bit SIGNED_EN  = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Valid_In,
    output logic                      Ready_Out,
    input  logic                      Signed_Mode_In,
    input  logic [DATA_WIDTH-1:0]     Data_A_In,
    input  logic [DATA_WIDTH-1:0]     Data_B_In,
    output logic                      Valid_Out,
    input  logic                      Ready_In,
    output logic                      Busy_Out,
    output logic [2*DATA_WIDTH-1:0]   Multiplied_Result_Out
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CW-1:0] c_COUNT_INIT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] c_COUNT_LAST = CW'(1);

    logic [1:0]            r_state_q,  w_state_d;
    logic [CW-1:0]         r_count_q,  w_count_d;
    logic [PW-1:0]         r_mcand_q,  w_mcand_d;   // multiplicand magnitude, pre-shifted
    logic [DATA_WIDTH-1:0] r_mplier_q, w_mplier_d;  // multiplier magnitude, consumed LSB first
    logic [PW-1:0]         r_acc_q,    w_acc_d;
    logic                  r_negate_q, w_negate_d;
    logic [PW-1:0]         r_result_q, w_result_d;
    logic                  r_valid_q,  w_valid_d;

    logic                  w_mode;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic [PW-1:0]         w_addend;
    logic [PW-1:0]         w_acc_next;
    logic                  w_accept;
    logic                  w_handshake;

    assign w_mode  = Signed_Mode_In & SIGNED_EN;
    assign w_a_neg = w_mode & Data_A_In[DATA_WIDTH-1];
    assign w_b_neg = w_mode & Data_B_In[DATA_WIDTH-1];

    // Negating the most negative value wraps back to 2^(N-1), which is the
    // correct magnitude when read as N-bit unsigned.
    assign w_mag_a = w_a_neg ? (-Data_A_In) : Data_A_In;
    assign w_mag_b = w_b_neg ? (-Data_B_In) : Data_B_In;

    // Shifting the multiplicand one place per iteration is equivalent to
    // adding mag_a << (N - count) on every step.
    assign w_addend   = r_mplier_q[0] ? r_mcand_q : '0;
    assign w_acc_next = r_acc_q + w_addend;

    assign w_accept    = Valid_In & (r_state_q == c_IDLE);
    assign w_handshake = r_valid_q & Ready_In;

    always_comb begin
        w_state_d  = r_state_q;
        w_count_d  = r_count_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_acc_d    = r_acc_q;
        w_negate_d = r_negate_q;
        w_result_d = r_result_q;
        w_valid_d  = r_valid_q;

        case (r_state_q)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_d  = c_CALC;
                    w_count_d  = c_COUNT_INIT;
                    w_mcand_d  = {{DATA_WIDTH{1'b0}}, w_mag_a};
                    w_mplier_d = w_mag_b;
                    w_acc_d    = '0;
                    // Only the product sign is needed later, so the mode and
                    // both operand signs collapse into one flag.
                    w_negate_d = w_a_neg ^ w_b_neg;
                end
            end
            c_CALC: begin
                w_acc_d    = w_acc_next;
                w_mcand_d  = r_mcand_q << 1;
                w_mplier_d = r_mplier_q >> 1;
                w_count_d  = r_count_q - c_COUNT_LAST;
                if (r_count_q == c_COUNT_LAST) begin
                    w_result_d = r_negate_q ? (-w_acc_next) : w_acc_next;
                    w_valid_d  = 1'b1;
                    w_state_d  = c_DONE;
                end
            end
            c_DONE: begin
                // Result register keeps its value after the handshake.
                if (w_handshake) begin
                    w_valid_d = 1'b0;
                    w_state_d = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q  <= c_IDLE;
            r_count_q  <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_acc_q    <= '0;
            r_negate_q <= 1'b0;
            r_result_q <= '0;
            r_valid_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_count_q  <= w_count_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_acc_q    <= w_acc_d;
            r_negate_q <= w_negate_d;
            r_result_q <= w_result_d;
            r_valid_q  <= w_valid_d;
        end
    end

    assign Ready_Out             = (r_state_q == c_IDLE);
    assign Busy_Out              = (r_state_q == c_CALC);
    assign Valid_Out             = r_valid_q;
    assign Multiplied_Result_Out = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_shift_add_multiplier
// Description : Scoreboard bench for three multiplier instances sharing one
//               stimulus stream: 32-bit signed-capable, 8-bit signed-capable,
//               and 8-bit with signed mode disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_shift_add_multiplier;

    typedef struct {
        logic [63:0] exp;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  bsy;
    logic [63:0] res32;
    logic [15:0] res8s;
    logic [15:0] res8u;
    logic [63:0] res [3];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rand_ready = 0;
    exp_t q [3][$];
    logic [63:0] held [3];
    logic [2:0]  prev_v = '0;
    logic        prev_ri = 1'b0;
    int   nw [3] = '{32, 8, 8};

    sequential_shift_add_multiplier #(.DATA_WIDTH(32), .SIGNED_EN(1'b1)) u_dut32 (
        .Clk(clk), .Reset(rst), .Valid_In(valid_in), .Ready_Out(rdy[0]),
        .Signed_Mode_In(mode), .Data_A_In(a), .Data_B_In(b),
        .Valid_Out(vld[0]), .Ready_In(ready_in), .Busy_Out(bsy[0]),
        .Multiplied_Result_Out(res32));

    sequential_shift_add_multiplier #(.DATA_WIDTH(8), .SIGNED_EN(1'b1)) u_dut8s (
        .Clk(clk), .Reset(rst), .Valid_In(valid_in), .Ready_Out(rdy[1]),
        .Signed_Mode_In(mode), .Data_A_In(a[7:0]), .Data_B_In(b[7:0]),
        .Valid_Out(vld[1]), .Ready_In(ready_in), .Busy_Out(bsy[1]),
        .Multiplied_Result_Out(res8s));

    sequential_shift_add_multiplier #(.DATA_WIDTH(8), .SIGNED_EN(1'b0)) u_dut8u (
        .Clk(clk), .Reset(rst), .Valid_In(valid_in), .Ready_Out(rdy[2]),
        .Signed_Mode_In(mode), .Data_A_In(a[7:0]), .Data_B_In(b[7:0]),
        .Valid_Out(vld[2]), .Ready_In(ready_in), .Busy_Out(bsy[2]),
        .Multiplied_Result_Out(res8u));

    assign res[0] = res32;
    assign res[1] = {48'b0, res8s};
    assign res[2] = {48'b0, res8u};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer products of the operands as the instance sees them.
    function automatic logic [63:0] model(int d, logic [31:0] ia, logic [31:0] ib, logic im);
        longint      p;
        int          s;
        logic [15:0] u;
        logic [7:0]  a8;
        logic [7:0]  b8;
        a8 = ia[7:0];
        b8 = ib[7:0];
        if (d == 0) begin
            if (im) begin
                p = longint'($signed(ia)) * longint'($signed(ib));
                return 64'(p);
            end
            return {32'b0, ia} * {32'b0, ib};
        end
        if (d == 1 && im) begin
            s = int'($signed(a8)) * int'($signed(b8));
            return {48'b0, s[15:0]};
        end
        u = {8'b0, a8} * {8'b0, b8};
        return {48'b0, u};
    endfunction

    task automatic check(string nm, int d, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h (cycle %0d)", nm, d, got, want, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                q[d].delete();
                prev_v[d] = 1'b0;
            end else begin
                if (prev_v[d])
                    check("valid_after_edge", d, 64'(vld[d]), 64'(!prev_ri));
                check("busy_flag", d, 64'(bsy[d]), 64'(!rdy[d] && !vld[d]));
                if (vld[d] && !prev_v[d]) begin
                    if (q[d].size() == 0) begin
                        check("spurious_valid", d, 64'd1, 64'd0);
                    end else begin
                        e = q[d].pop_front();
                        check("result", d, res[d], e.exp);
                        check("latency", d, 64'(cyc - e.acc), 64'(nw[d]));
                        held[d] = e.exp;
                    end
                end else if (vld[d]) begin
                    check("hold_result", d, res[d], held[d]);
                end
                prev_v[d] = vld[d];
                if (valid_in && rdy[d])
                    q[d].push_back('{model(d, a, b, mode), cyc + 1});
            end
        end
        prev_ri = ready_in;
    end

    // Random result-side backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_op(logic [31:0] ia, logic [31:0] ib, logic im);
        int w;
        w = 0;
        while (!rdy[0] && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("ready_wait", 0, 64'(rdy[0]), 64'd1);
        a        = ia;
        b        = ib;
        mode     = im;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        a        = $urandom;
        b        = $urandom;
        mode     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!vld[0] && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("valid_wait", 0, 64'(vld[0]), 64'd1);
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FF80;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", d, 64'(rdy[d]), 64'd1);
            check("reset_valid", d, 64'(vld[d]), 64'd0);
            check("reset_busy", d, 64'(bsy[d]), 64'd0);
            check("reset_result", d, res[d], 64'd0);
        end
        rst = 1'b0;

        // Abort mid-calculation
        do_op(32'd5, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("mid_calc_busy", 0, 64'(bsy[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("abort_ready", d, 64'(rdy[d]), 64'd1);
            check("abort_valid", d, 64'(vld[d]), 64'd0);
            check("abort_result", d, res[d], 64'd0);
        end

        // Directed boundary products
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_valid();
        check("u32_max", 0, res[0], 64'hFFFF_FFFE_0000_0001);
        check("u8_max", 2, res[2], 64'h0000_0000_0000_FE01);
        release_result();

        do_op(32'h0000_0080, 32'h0000_0080, 1'b1);
        wait_valid();
        check("s8_min_sq", 1, res[1], 64'h4000);
        check("s32_pos_0x80_sq", 0, res[0], 64'h4000);
        release_result();

        do_op(32'h0000_00FD, 32'h0000_0007, 1'b1);
        wait_valid();
        check("s8_neg3_x7", 1, res[1], 64'hFFEB);
        check("u8_253_x7", 2, res[2], 64'h06EB);
        release_result();

        do_op(32'h0000_00FF, 32'h0000_00FF, 1'b1);
        wait_valid();
        check("signed_en0_ignores_mode", 2, res[2], 64'hFE01);
        check("s8_neg1_sq", 1, res[1], 64'h0001);
        release_result();

        do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_valid();
        check("s32_min_sq", 0, res[0], 64'h4000_0000_0000_0000);
        release_result();

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_valid();
        check("s32_neg1_x1", 0, res[0], 64'hFFFF_FFFF_FFFF_FFFF);
        release_result();

        // Backpressure with ignored Valid_In pulses
        do_op(32'h0001_2345, 32'hDEAD_BEEF, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            valid_in = (i % 2 == 0);
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check("stall_valid_held", 0, 64'(vld[0]), 64'd1);
        check("stall_ready_low", 0, 64'(rdy[0]), 64'd0);
        release_result();
        check("to_idle_ready", 0, 64'(rdy[0]), 64'd1);
        check("to_idle_valid", 0, 64'(vld[0]), 64'd0);

        // Randomized operations with random result stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++)
            do_op(pick(), pick(), 1'($urandom_range(0, 1)));

        // Drain
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        ready_in   = 1'b1;
        for (int w = 0; w < 200; w++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && vld == 3'b000)
                break;
            @(posedge clk);
            #1;
        end
        for (int d = 0; d < 3; d++)
            check("drain_empty", d, 64'(q[d].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
